// File: rtl/tristate_bus_ctrl_if.sv
// Requester-side handshake and pad-side control bundle for tristate_bus_ctrl.
// WIDTH and NREQ must match the parameters of the attached controller.
interface tristate_bus_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 2
);
    logic [NREQ-1:0]       i_req;
    logic [NREQ-1:0]       i_we;
    logic [NREQ*WIDTH-1:0] i_wdata;
    logic [NREQ-1:0]       o_ack;
    logic [WIDTH-1:0]      o_rdata;
    logic                  o_busy;
    logic [WIDTH-1:0]      o_bus_dir;
    logic [WIDTH-1:0]      o_bus_out;
    logic [WIDTH-1:0]      i_bus_in;
    logic                  o_bus_strobe;
    logic                  o_bus_rw;

    // Controller side.
    modport slave (
        input  i_req, i_we, i_wdata, i_bus_in,
        output o_ack, o_rdata, o_busy, o_bus_dir, o_bus_out, o_bus_strobe, o_bus_rw
    );

    // Requesters plus the pad buffer model.
    modport master (
        output i_req, i_we, i_wdata, i_bus_in,
        input  o_ack, o_rdata, o_busy, o_bus_dir, o_bus_out, o_bus_strobe, o_bus_rw
    );
endinterface

// File: rtl/tristate_bus_ctrl.sv
// Arbitrates NREQ requesters onto one tristate bus: SETUP/STROBE/HOLD cycles, TURN after reads.
// Define TRISTATE_BUS_CTRL_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round robin.
module tristate_bus_ctrl #(
    parameter int WIDTH         = 8,
    parameter int NREQ          = 2,
    parameter int STROBE_CYCLES = 2,
    parameter int TURNAROUND    = 1
) (
    input  logic               i_clk,
    input  logic               i_reset,
    tristate_bus_ctrl_if.slave bus
);
    localparam int IDX_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_MAX = (STROBE_CYCLES > TURNAROUND) ? STROBE_CYCLES : TURNAROUND;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_TURN
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] owner;
    logic             owner_we;
    logic [CNT_W-1:0] cnt;

    logic             grant_valid;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_we;
    logic [WIDTH-1:0] grant_wdata;

`ifdef TRISTATE_BUS_CTRL_FIXED_PRIO_EN
    // Descending scan: the last hit, i.e. the lowest requesting index, wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (|(bus.i_req & (NREQ'(1) << i))) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(i);
            end
        end
    end
`else
    logic [IDX_W-1:0] rr_ptr;

    // Scan offsets from the pointer downwards so the nearest requester at or after it wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (|(bus.i_req & (NREQ'(1) << ((int'(rr_ptr) + i) % NREQ)))) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'((int'(rr_ptr) + i) % NREQ);
            end
        end
    end
`endif

    assign grant_we    = |(bus.i_we & (NREQ'(1) << grant_idx));
    assign grant_wdata = WIDTH'(bus.i_wdata >> (int'(grant_idx) * WIDTH));

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state            <= ST_IDLE;
            owner            <= '0;
            owner_we         <= 1'b0;
            cnt              <= '0;
            bus.o_ack        <= '0;
            bus.o_rdata      <= '0;
            bus.o_busy       <= 1'b0;
            bus.o_bus_dir    <= '0;
            bus.o_bus_out    <= '0;
            bus.o_bus_strobe <= 1'b0;
            bus.o_bus_rw     <= 1'b0;
`ifndef TRISTATE_BUS_CTRL_FIXED_PRIO_EN
            rr_ptr           <= '0;
`endif
        end else begin
            bus.o_ack <= '0;
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        state         <= ST_SETUP;
                        owner         <= grant_idx;
                        owner_we      <= grant_we;
                        bus.o_busy    <= 1'b1;
                        bus.o_bus_rw  <= grant_we;
                        bus.o_bus_dir <= {WIDTH{grant_we}};
                        bus.o_bus_out <= grant_we ? grant_wdata : '0;
`ifndef TRISTATE_BUS_CTRL_FIXED_PRIO_EN
                        rr_ptr        <= IDX_W'((int'(grant_idx) + 1) % NREQ);
`endif
                    end
                end

                ST_SETUP: begin
                    state            <= ST_STROBE;
                    cnt              <= '0;
                    bus.o_bus_strobe <= 1'b1;
                end

                ST_STROBE: begin
                    if (cnt == CNT_W'(STROBE_CYCLES - 1)) begin
                        state            <= ST_HOLD;
                        bus.o_bus_strobe <= 1'b0;
                        bus.o_ack        <= NREQ'(1) << owner;
                        if (!owner_we) begin
                            bus.o_rdata <= bus.i_bus_in;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_HOLD: begin
                    cnt           <= '0;
                    bus.o_bus_dir <= '0;
                    bus.o_bus_out <= '0;
                    if (owner_we || TURNAROUND == 0) begin
                        state        <= ST_IDLE;
                        bus.o_busy   <= 1'b0;
                        bus.o_bus_rw <= 1'b0;
                    end else begin
                        state <= ST_TURN;
                    end
                end

                ST_TURN: begin
                    // Bus stays released until the external device has let go of it.
                    if (cnt == CNT_W'(TURNAROUND - 1)) begin
                        state        <= ST_IDLE;
                        bus.o_busy   <= 1'b0;
                        bus.o_bus_rw <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state            <= ST_IDLE;
                    bus.o_busy       <= 1'b0;
                    bus.o_bus_dir    <= '0;
                    bus.o_bus_strobe <= 1'b0;
                end
            endcase
        end
    end

    // Structural invariants of the registered outputs.
    a_ack_onehot : assert property (@(posedge i_clk) disable iff (i_reset)
        $onehot0(bus.o_ack));
    a_dir_uniform : assert property (@(posedge i_clk) disable iff (i_reset)
        (bus.o_bus_dir == '0) || (bus.o_bus_dir == '1));
    a_turn_released : assert property (@(posedge i_clk) disable iff (i_reset)
        (state == ST_TURN) |-> (bus.o_bus_dir == '0 && !bus.o_bus_strobe));
    a_busy_state : assert property (@(posedge i_clk) disable iff (i_reset)
        bus.o_busy == (state != ST_IDLE));
    a_strobe_state : assert property (@(posedge i_clk) disable iff (i_reset)
        bus.o_bus_strobe == (state == ST_STROBE));
endmodule
